// File: rtl/pipe_addacc_pkg.sv
// Shared types and default sizes for the pipelined add/accumulate block.
package pipe_addacc_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/addacc_core.sv
// Combinational arithmetic for one beat: add, subtract, accumulate, clear.
// Define PIPE_ADDACC_SAT_EN to clamp results instead of wrapping.
module addacc_core
  import pipe_addacc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] acc_i,
  input  mode_t            mode_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic [WIDTH-1:0] next_acc_o
);

  logic [WIDTH:0] sum_add;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] acc_sum;

  always_comb begin
    sum_add    = {1'b0, a_i} + {1'b0, b_i};
    diff       = {1'b0, a_i} - {1'b0, b_i};
    acc_sum    = {1'b0, acc_i} + {1'b0, a_i};
    result_o   = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    next_acc_o = acc_i;
    case (mode_i)
      MODE_ADD: begin
        result_o   = sum_add[WIDTH-1:0];
        carry_o    = sum_add[WIDTH];
        overflow_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_add[WIDTH-1] != a_i[WIDTH-1]);
`ifdef PIPE_ADDACC_SAT_EN
        if (sum_add[WIDTH]) result_o = '1;
`endif
      end
      MODE_SUB: begin
        // The extra top bit of the difference is the borrow, i.e. a < b.
        result_o   = diff[WIDTH-1:0];
        carry_o    = diff[WIDTH];
        overflow_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
`ifdef PIPE_ADDACC_SAT_EN
        if (diff[WIDTH]) result_o = '0;
`endif
      end
      MODE_ACC: begin
        result_o   = acc_sum[WIDTH-1:0];
        carry_o    = acc_sum[WIDTH];
        overflow_o = (acc_i[WIDTH-1] == a_i[WIDTH-1]) && (acc_sum[WIDTH-1] != acc_i[WIDTH-1]);
`ifdef PIPE_ADDACC_SAT_EN
        if (acc_sum[WIDTH]) result_o = '1;
`endif
        next_acc_o = result_o;
      end
      MODE_CLR: begin
        next_acc_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_addacc.sv
// Two-stage valid/ready add/sub/accumulate pipeline with delivered-result counter.
// Optional saturation via PIPE_ADDACC_SAT_EN (handled in addacc_core).
module pipe_addacc
  import pipe_addacc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic [CNT_W-1:0] res_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  mode_t            s1_mode_q, s1_mode_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_adv;
  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_overflow;
  logic [WIDTH-1:0] core_next_acc;

  // Ready looks only at the downstream side so it never depends on in_valid.
  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  addacc_core #(.WIDTH(WIDTH)) u_core (
    .a_i        (s1_a_q),
    .b_i        (s1_b_q),
    .acc_i      (acc_q),
    .mode_i     (s1_mode_q),
    .result_o   (core_result),
    .carry_o    (core_carry),
    .overflow_o (core_overflow),
    .next_acc_o (core_next_acc)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_mode_d   = s1_mode_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d    = a;
        s1_b_d    = b;
        s1_mode_d = mode_t'(mode);
      end
    end

    // The accumulator commits only on the S1->S2 move, so chained ACC beats see each other.
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d   = core_result;
        carry_d    = core_carry;
        overflow_d = core_overflow;
        acc_d      = core_next_acc;
      end
    end

    if (out_valid_q && out_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= MODE_ADD;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign res_count = cnt_q;

endmodule
